// File: rtl/dino_pkg.sv
// Shared constants for the score path: BCD nibble geometry, double-dabble
// correction constants and the converter state encoding.
package dino_pkg;

    localparam int        BCD_DIGIT_W     = 4;
    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADD3        = 4'd3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    // Largest value representable in n decimal digits, plus one.
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned acc;
        acc = 1;
        for (int unsigned i = 0; i < n; i++) begin
            acc = acc * 10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import dino_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] nibble,
    output logic [BCD_DIGIT_W-1:0] corrected
);

    // The nibble is never above 9 here, so the 4-bit sum cannot wrap.
    assign corrected = (nibble >= BCD_ADD3_THRESH) ? nibble + BCD_ADD3 : nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the score display.
// Optional feature: define LEADING_ZERO_BLANK_EN to drive a leading-zero blank mask.
module bin_to_bcd_seq
    import dino_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin_in,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                        overflow,
    output logic [DIGITS-1:0]           digit_blank
);

    localparam int          SCR_W   = BCD_DIGIT_W * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

    state_t             state_reg;
    logic [BIN_W-1:0]   shift_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [SCR_W-1:0]   scratch_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [SCR_W-1:0]   bcd_reg;
    logic               ovf_reg;
    logic               done_reg;

    logic [SCR_W-1:0]   scratch_corr;
    logic               ovf_next;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .nibble    (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .corrected (scratch_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Judged on the latched input; values past the display range saturate.
    assign ovf_next = (32'(bin_reg) > MAX_VAL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bin_reg     <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_reg     <= bin_in;
                        shift_reg   <= bin_in;
                        scratch_reg <= '0;
                        cnt_reg     <= CNT_W'(BIN_W);
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch_reg, shift_reg} <= {scratch_corr, shift_reg} << 1;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b1;
                    ovf_reg   <= ovf_next;
                    bcd_reg   <= ovf_next ? {DIGITS{4'h9}} : scratch_reg;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign bcd_out  = bcd_reg;
    assign overflow = ovf_reg;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_reg;

    // Digit i blanks only when it and every digit above it are zero.
    assign blank_next[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank_next[gi] = ~ovf_next &&
                (scratch_reg[SCR_W-1:gi*BCD_DIGIT_W] == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blank_reg <= '0;
        end else if (state_reg == DONE) begin
            blank_reg <= blank_next;
        end
    end

    assign digit_blank = blank_reg;
`else
    assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq with hand-computed BCD results.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;
    logic [3:0]  digit_blank;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out),
        .overflow    (overflow),
        .digit_blank (digit_blank)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion from IDLE; expected blank mask applies only with the feature on.
    task automatic run_conv(input logic [13:0] value, input logic [15:0] exp_bcd,
                            input logic exp_ovf, input logic [3:0] exp_blank_on);
        int cycles;
        int busy_cnt;
        logic [3:0] exp_blank;
`ifdef LEADING_ZERO_BLANK_EN
        exp_blank = exp_blank_on;
`else
        exp_blank = 4'b0000;
`endif
        start  = 1'b1;
        bin_in = value;
        tick();
        start  = 1'b0;
        bin_in = ~value;
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            tick();
            cycles++;
        end
        $display("conv bin=%0d bcd=%h ovf=%0b blank=%b latency=%0d busy=%0d",
                 value, bcd_out, overflow, digit_blank, cycles, busy_cnt);
        check("latency", cycles, 15);
        check("busy_len", busy_cnt, 15);
        check("bcd", bcd_out, exp_bcd);
        check("ovf", overflow, exp_ovf);
        check("blank", digit_blank, exp_blank);
        tick();
        check("done_pulse", done, 1'b0);
        check("bcd_hold", bcd_out, exp_bcd);
    endtask

    initial begin
        int dones;
        int first_done;
        int second_done;
        logic [15:0] seen_bcd;

        resetn = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_ovf", overflow, 1'b0);
        check("rst_blank", digit_blank, 4'b0000);
        resetn = 1'b1;
        tick();

        run_conv(14'd0,     16'h0000, 1'b0, 4'b1110);
        run_conv(14'd1234,  16'h1234, 1'b0, 4'b0000);
        run_conv(14'd9999,  16'h9999, 1'b0, 4'b0000);
        run_conv(14'd10000, 16'h9999, 1'b1, 4'b0000);
        run_conv(14'd16383, 16'h9999, 1'b1, 4'b0000);
        run_conv(14'd42,    16'h0042, 1'b0, 4'b1100);
        run_conv(14'd7,     16'h0007, 1'b0, 4'b1110);

        // start during busy must be ignored
        start  = 1'b1;
        bin_in = 14'd1234;
        tick();
        start  = 1'b0;
        dones  = 0;
        seen_bcd = '0;
        for (int c = 1; c < 40; c++) begin
            if (c == 5)  begin start = 1'b1; bin_in = 14'd42; end
            if (c == 11) start = 1'b0;
            if (done) begin dones++; seen_bcd = bcd_out; end
            tick();
        end
        $display("busy_start dones=%0d bcd=%h", dones, seen_bcd);
        check("ign_dones", dones, 1);
        check("ign_bcd", seen_bcd, 16'h1234);

        // reset mid-conversion aborts without a done pulse
        start  = 1'b1;
        bin_in = 14'd9999;
        tick();
        start  = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        resetn = 1'b0;
        #2;
        check("abort_busy", busy, 1'b0);
        check("abort_bcd", bcd_out, 16'h0000);
        check("abort_done", done, 1'b0);
        tick();
        resetn = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) dones++;
            tick();
        end
        $display("abort dones=%0d", dones);
        check("abort_nodone", dones, 0);
        run_conv(14'd56, 16'h0056, 1'b0, 4'b1100);

        // start held high: back-to-back conversions every BIN_W+2 cycles
        start  = 1'b1;
        bin_in = 14'd7;
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c < 60 && second_done < 0; c++) begin
            if (done) begin
                if (first_done < 0) first_done = c;
                else second_done = c;
            end
            tick();
        end
        start = 1'b0;
        $display("held_start first=%0d second=%0d", first_done, second_done);
        check("held_period", second_done - first_done, 16);
        check("held_bcd", bcd_out, 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
